uart_tx_fifo: RTL

Parametrised UART transmitter with an integrated transmit FIFO, configurable frame format and a derived baud timer. It replaces the single-word, fixed 8-bit odd-parity transmitter in the serial output path. Upstream logic can queue several words without waiting on a per-word handshake, and frames go out back-to-back on `Sout`.

---
 rtl/uart_tx_fifo.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small circular FIFO. Frames are
// start bit, DATA_BITS data bits (LSB first), an optional parity bit and one
// or two stop bits. Queued words go out back-to-back on Sout.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 19_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] Din,
  input  logic                 Wr,
  output logic                 Full,
  output logic                 Empty,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Overflow,
  output logic                 Sout
);

  localparam int BIT_CYCLES = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int TW = $clog2(BIT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_ZERO = TW'(0);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(BIT_CYCLES - 2);
  localparam logic [AW-1:0] A_ZERO = AW'(0);
  localparam logic [AW-1:0] A_ONE  = AW'(1);
  localparam logic [CW-1:0] C_ZERO = CW'(0);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] B_ZERO = BW'(0);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Parity bit of a latched word for the configured parity mode
  function automatic logic parity_of(input logic [DATA_BITS-1:0] word);
    if (PARITY == 1) begin
      return ^word;
    end else begin
      return ~^word;
    end
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]        count_r, count_nxt_s;
  logic                 full_r, empty_r, ovf_r;
  logic                 wr_ok_s, pop_s, tick_s;
  logic [DATA_BITS-1:0] head_s;

  state_t               state_r;
  logic [TW-1:0]        timer_r;
  logic [BW-1:0]        bit_idx_r;
  logic                 stop_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r, sout_r, busy_r, done_r;

  assign head_s = mem_r[rd_ptr_r];

  // Decode write acceptance, pop requests and the next FIFO occupancy
  always_comb begin
    tick_s  = (timer_r == T_LAST);
    wr_ok_s = Wr & ~full_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE:    pop_s = ~empty_r;
      STOP:    pop_s = tick_s & (stop_idx_r == S_LAST) & ~empty_r;
      default: pop_s = 1'b0;
    endcase
    count_nxt_s = count_r;
    case ({wr_ok_s, pop_s})
      2'b10:   count_nxt_s = count_r + C_ONE;
      2'b01:   count_nxt_s = count_r - C_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; flushing is done through the pointers, not the array
  always_ff @(posedge clk) begin
    if (wr_ok_s && !Reset) begin
      mem_r[wr_ptr_r] <= Din;
    end
  end

  // FIFO pointers, occupancy, flags and sticky overflow
  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_r <= A_ZERO;
      rd_ptr_r <= A_ZERO;
      count_r  <= C_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + A_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + A_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == C_FULL);
      empty_r <= (count_nxt_s == C_ZERO);
      if (Wr && full_r) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Frame sequencer with baud timer and registered line/status outputs
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_r    <= IDLE;
      timer_r    <= T_ZERO;
      bit_idx_r  <= B_ZERO;
      stop_idx_r <= 1'b0;
      shift_r    <= {DATA_BITS{1'b0}};
      par_r      <= 1'b0;
      sout_r     <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state_r != IDLE) begin
        timer_r <= tick_s ? T_ZERO : timer_r + T_ONE;
      end
      case (state_r)
        IDLE: begin
          sout_r <= 1'b1;
          busy_r <= 1'b0;
          if (pop_s) begin
            shift_r <= head_s;
            par_r   <= parity_of(head_s);
            timer_r <= T_ZERO;
            state_r <= START;
            sout_r  <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          if (tick_s) begin
            state_r   <= DATA;
            bit_idx_r <= B_ZERO;
            sout_r    <= shift_r[0];
          end
        end
        DATA: begin
          if (tick_s) begin
            if (bit_idx_r == B_LAST) begin
              if (PARITY != 0) begin
                state_r <= PAR;
                sout_r  <= par_r;
              end else begin
                state_r    <= STOP;
                stop_idx_r <= 1'b0;
                sout_r     <= 1'b1;
              end
            end else begin
              bit_idx_r <= bit_idx_r + B_ONE;
              shift_r   <= {1'b0, shift_r[DATA_BITS-1:1]};
              sout_r    <= shift_r[1];
            end
          end
        end
        PAR: begin
          if (tick_s) begin
            state_r    <= STOP;
            stop_idx_r <= 1'b0;
            sout_r     <= 1'b1;
          end
        end
        STOP: begin
          if ((timer_r == T_PRE) && (stop_idx_r == S_LAST)) begin
            done_r <= 1'b1;
          end
          if (tick_s) begin
            if (stop_idx_r != S_LAST) begin
              stop_idx_r <= stop_idx_r + 1'b1;
            end else if (pop_s) begin
              shift_r <= head_s;
              par_r   <= parity_of(head_s);
              state_r <= START;
              sout_r  <= 1'b0;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              sout_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          sout_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Full     = full_r;
  assign Empty    = empty_r;
  assign Overflow = ovf_r;
  assign Busy     = busy_r;
  assign Done     = done_r;
  assign Sout     = sout_r;

endmodule
